// File: rtl/mini_src_pkg.sv
// Shared Mini SRC definitions: branch condition encodings, where the condition
// field sits in the instruction register, and the branch unit FSM states.
package mini_src_pkg;

   localparam logic [2:0] COND_ZERO   = 3'b000;
   localparam logic [2:0] COND_NZERO  = 3'b001;
   localparam logic [2:0] COND_POS    = 3'b010;
   localparam logic [2:0] COND_NEG    = 3'b011;
   localparam logic [2:0] COND_ALWAYS = 3'b100;
   localparam logic [2:0] COND_NEVER  = 3'b101;
   localparam logic [2:0] COND_SLT    = 3'b110;
   localparam logic [2:0] COND_EQ     = 3'b111;

   localparam int COND_FIELD_LSB = 19;
   localparam int COND_FIELD_MSB = 21;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ARMED = 1'b1
   } bcu_state_e;

   // Codes 11x compare a captured first operand against the bus.
   function automatic logic is_two_operand(input logic [2:0] code);
      return code[2:1] == 2'b11;
   endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational branch condition evaluator; single-operand codes ignore a_in,
// two-operand codes compare a_in against bus_in.
module cond_eval
   import mini_src_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]            code,
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic [DATA_WIDTH-1:0] bus_in,
   output logic                  result
);

   always_comb begin
      result = 1'b0;
      case (code)
         COND_ZERO:   result = (bus_in == '0);
         COND_NZERO:  result = (bus_in != '0);
         COND_POS:    result = ~bus_in[DATA_WIDTH-1];
         COND_NEG:    result = bus_in[DATA_WIDTH-1];
         COND_ALWAYS: result = 1'b1;
         COND_NEVER:  result = 1'b0;
         COND_SLT:    result = ($signed(a_in) < $signed(bus_in));
         COND_EQ:     result = (a_in == bus_in);
         default:     result = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_cond_unit.sv
// Branch condition register for the Mini SRC control unit: evaluates a condition
// per strobe, captures a first operand for two-operand codes, keeps statistics.
module branch_cond_unit
   import mini_src_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int HIST_DEPTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic [2:0]            cond_code,
   input  logic [DATA_WIDTH-1:0] bus_in,
   input  logic                  con_in,
   output logic                  con,
   output logic                  con_valid,
   output logic                  busy,
   output logic [HIST_DEPTH-1:0] hist,
   output logic [CNT_WIDTH-1:0]  taken_cnt,
   output logic [CNT_WIDTH-1:0]  eval_cnt
);

   bcu_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic                  con_q, con_d;
   logic                  con_valid_q, con_valid_d;
   logic [HIST_DEPTH-1:0] hist_q, hist_d, hist_shifted;
   logic [CNT_WIDTH-1:0]  taken_q, taken_d;
   logic [CNT_WIDTH-1:0]  eval_q, eval_d;

   logic two_op;
   logic capture;
   logic complete;
   logic result;

   cond_eval #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_cond_eval (
      .code   (cond_code),
      .a_in   (a_q),
      .bus_in (bus_in),
      .result (result)
   );

   generate
      if (HIST_DEPTH == 1) begin : g_hist_one
         assign hist_shifted = result;
      end else begin : g_hist_many
         assign hist_shifted = {hist_q[HIST_DEPTH-2:0], result};
      end
   endgenerate

   assign two_op   = is_two_operand(cond_code);
   assign capture  = con_in && (state_q == ST_IDLE) && two_op;
   // Any other strobe completes; an ARMED unit seeing a single-operand code drops A.
   assign complete = con_in && !capture;

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      con_d       = con_q;
      con_valid_d = 1'b0;
      hist_d      = hist_q;
      taken_d     = taken_q;
      eval_d      = eval_q;

      if (capture) begin
         state_d = ST_ARMED;
         a_d     = bus_in;
      end

      if (complete) begin
         state_d     = ST_IDLE;
         con_d       = result;
         con_valid_d = 1'b1;
         hist_d      = hist_shifted;
         if (eval_q != '1) begin
            eval_d = eval_q + CNT_WIDTH'(1);
         end
         if (result && (taken_q != '1)) begin
            taken_d = taken_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         con_q       <= 1'b0;
         con_valid_q <= 1'b0;
         hist_q      <= '0;
         taken_q     <= '0;
         eval_q      <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         con_q       <= con_d;
         con_valid_q <= con_valid_d;
         hist_q      <= hist_d;
         taken_q     <= taken_d;
         eval_q      <= eval_d;
      end
   end

   assign con       = con_q;
   assign con_valid = con_valid_q;
   assign busy      = (state_q == ST_ARMED);
   assign hist      = hist_q;
   assign taken_cnt = taken_q;
   assign eval_cnt  = eval_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed bench for branch_cond_unit: a reference model queues the expected
// outcome per strobe, popped and compared on each con_valid pulse.
module tb_branch_cond_unit;

   logic        clk = 1'b0;
   logic        clear;
   logic [2:0]  cond_code;
   logic [31:0] bus_in;
   logic        con_in;
   logic        con_in_s;

   logic        con, con_valid, busy;
   logic [7:0]  hist;
   logic [15:0] taken_cnt, eval_cnt;

   logic        con_s, con_valid_s, busy_s;
   logic [3:0]  hist_s;
   logic [3:0]  taken_s, eval_s;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        con;
      logic [7:0]  hist;
      logic [15:0] ev;
      logic [15:0] tk;
   } exp_t;

   exp_t sb_q[$];

   logic        m_armed;
   logic [31:0] m_a;
   logic        m_con;
   logic [7:0]  m_hist;
   logic [15:0] m_eval, m_taken;

   always #5 clk = ~clk;

   branch_cond_unit #(.DATA_WIDTH(32), .HIST_DEPTH(8), .CNT_WIDTH(16)) dut (
      .clk(clk), .clear(clear), .cond_code(cond_code), .bus_in(bus_in),
      .con_in(con_in), .con(con), .con_valid(con_valid), .busy(busy),
      .hist(hist), .taken_cnt(taken_cnt), .eval_cnt(eval_cnt)
   );

   branch_cond_unit #(.DATA_WIDTH(32), .HIST_DEPTH(4), .CNT_WIDTH(4)) dut_sat (
      .clk(clk), .clear(clear), .cond_code(cond_code), .bus_in(bus_in),
      .con_in(con_in_s), .con(con_s), .con_valid(con_valid_s), .busy(busy_s),
      .hist(hist_s), .taken_cnt(taken_s), .eval_cnt(eval_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic ref_eval(input logic [2:0] code, input logic [31:0] a,
                                     input logic [31:0] b);
      case (code)
         3'b000:  return b == 32'd0;
         3'b001:  return b != 32'd0;
         3'b010:  return !b[31];
         3'b011:  return b[31];
         3'b100:  return 1'b1;
         3'b101:  return 1'b0;
         3'b110:  return $signed(a) < $signed(b);
         default: return a == b;
      endcase
   endfunction

   task automatic model_reset();
      m_armed = 1'b0; m_a = '0; m_con = 1'b0; m_hist = '0; m_eval = '0; m_taken = '0;
      sb_q.delete();
   endtask

   task automatic check_cycle(input string tag, input logic exp_valid);
      exp_t e;
      chk({tag, ".con_valid"}, 32'(con_valid), 32'(exp_valid));
      chk({tag, ".busy"}, 32'(busy), 32'(m_armed));
      if (con_valid && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({tag, ".con"}, 32'(con), 32'(e.con));
         chk({tag, ".hist"}, 32'(hist), 32'(e.hist));
         chk({tag, ".eval_cnt"}, 32'(eval_cnt), 32'(e.ev));
         chk({tag, ".taken_cnt"}, 32'(taken_cnt), 32'(e.tk));
      end else begin
         chk({tag, ".con_hold"}, 32'(con), 32'(m_con));
      end
      $display("txn %s: code=%b bus=0x%08h con=%0b valid=%0b busy=%0b hist=0x%02h eval=%0d taken=%0d",
               tag, cond_code, bus_in, con, con_valid, busy, hist, eval_cnt, taken_cnt);
   endtask

   task automatic strobe(input string tag, input logic [2:0] code, input logic [31:0] bus,
                         input logic clr);
      logic done;
      logic res;
      exp_t e;
      done = 1'b0;
      if (clr) begin
         model_reset();
      end else if (!m_armed && code[2:1] == 2'b11) begin
         m_armed = 1'b1;
         m_a = bus;
      end else begin
         res = (m_armed && code[2:1] == 2'b11) ? ref_eval(code, m_a, bus)
                                                : ref_eval(code, 32'd0, bus);
         m_armed = 1'b0;
         m_con = res;
         m_hist = {m_hist[6:0], res};
         if (m_eval != 16'hFFFF) m_eval = m_eval + 16'd1;
         if (res && m_taken != 16'hFFFF) m_taken = m_taken + 16'd1;
         e.con = res; e.hist = m_hist; e.ev = m_eval; e.tk = m_taken;
         sb_q.push_back(e);
         done = 1'b1;
      end
      cond_code = code; bus_in = bus; con_in = 1'b1; clear = clr;
      @(posedge clk);
      #1;
      con_in = 1'b0; clear = 1'b0;
      check_cycle(tag, done);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         check_cycle(tag, 1'b0);
      end
   endtask

   initial begin
      clear = 1'b1; con_in = 1'b0; con_in_s = 1'b0; cond_code = 3'b000; bus_in = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      clear = 1'b0;
      chk("reset.con", 32'(con), 32'd0);
      chk("reset.con_valid", 32'(con_valid), 32'd0);
      chk("reset.busy", 32'(busy), 32'd0);
      chk("reset.hist", 32'(hist), 32'd0);
      chk("reset.eval_cnt", 32'(eval_cnt), 32'd0);
      chk("reset.taken_cnt", 32'(taken_cnt), 32'd0);

      strobe("zero_hit", 3'b000, 32'd0, 1'b0);
      chk("zero_hit.hist_abs", 32'(hist), 32'h01);
      idle("zero_gap", 1);
      strobe("zero_miss", 3'b000, 32'd1, 1'b0);
      chk("zero_miss.hist_abs", 32'(hist), 32'h02);

      strobe("neg", 3'b011, 32'hFFFF0000, 1'b0);
      strobe("pos", 3'b010, 32'hFFFF0000, 1'b0);
      strobe("nonzero", 3'b001, 32'h00000100, 1'b0);
      strobe("always", 3'b100, 32'h0, 1'b0);
      strobe("never", 3'b101, 32'h0, 1'b0);
      chk("mix.eval_abs", 32'(eval_cnt), 32'd7);
      chk("mix.taken_abs", 32'(taken_cnt), 32'd4);

      strobe("slt_a", 3'b110, 32'hFFFFFFFE, 1'b0);
      strobe("slt_b", 3'b110, 32'd5, 1'b0);
      chk("slt1.con_abs", 32'(con), 32'd1);
      strobe("slt_a2", 3'b110, 32'd5, 1'b0);
      strobe("slt_b2", 3'b110, 32'hFFFFFFFE, 1'b0);
      chk("slt2.con_abs", 32'(con), 32'd0);

      strobe("eq_a", 3'b111, 32'h1234, 1'b0);
      idle("eq_wait", 3);
      strobe("eq_b", 3'b111, 32'h1234, 1'b0);
      chk("eq.con_abs", 32'(con), 32'd1);
      strobe("eq_a2", 3'b111, 32'h1234, 1'b0);
      strobe("eq_b2", 3'b111, 32'h1235, 1'b0);

      strobe("abort_a", 3'b111, 32'd7, 1'b0);
      strobe("abort_zero", 3'b000, 32'd0, 1'b0);
      chk("abort.busy_abs", 32'(busy), 32'd0);

      strobe("clr_a", 3'b110, 32'd9, 1'b0);
      strobe("clr_hit", 3'b110, 32'd100, 1'b1);
      chk("clr.hist_abs", 32'(hist), 32'd0);
      chk("clr.eval_abs", 32'(eval_cnt), 32'd0);
      strobe("post_clr_a", 3'b111, 32'd0, 1'b0);
      strobe("post_clr_b", 3'b111, 32'd0, 1'b0);

      cond_code = 3'b100; bus_in = '0; con_in_s = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (i == 13) chk("sat.eval_14", 32'(eval_s), 32'd14);
      end
      con_in_s = 1'b0;
      @(posedge clk);
      #1;
      chk("sat.eval_cnt", 32'(eval_s), 32'd15);
      chk("sat.taken_cnt", 32'(taken_s), 32'd15);
      chk("sat.hist", 32'(hist_s), 32'hF);
      chk("sat.con", 32'(con_s), 32'd1);
      chk("sat.valid_drop", 32'(con_valid_s), 32'd0);
      $display("txn sat: eval=%0d taken=%0d hist=0x%0h", eval_s, taken_s, hist_s);
      chk("sb.empty", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
